alu_arbiter: RTL and testbench

Shares the single 32-bit ALU between the core execute stage (requester C) and the WOS filter sorting engine (requester F, which issues SLT/SLTU/SUB compares). Requests use valid/ready handshakes. Arbitration is round-robin, with an optional bounded lock that lets F issue back-to-back compare bursts. Each result is registered and returned one cycle after acceptance.

---
 rtl/alu_arbiter.sv | 89 ++++++++
 tb/tb_alu_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between core and filter, with bounded filter lock
module alu_arbiter #(
  parameter int LOCK_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_valid,
  output logic        c_ready,
  input  logic [31:0] c_op1,
  input  logic [31:0] c_op2,
  input  logic [2:0]  c_func3,
  input  logic        c_instr30,
  input  logic [1:0]  c_alu_op,
  input  logic        f_valid,
  output logic        f_ready,
  input  logic        f_lock,
  input  logic [31:0] f_op1,
  input  logic [31:0] f_op2,
  input  logic [2:0]  f_func3,
  input  logic        f_instr30,
  input  logic [1:0]  f_alu_op,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [2:0]  alu_func3,
  output logic        alu_instr30,
  output logic [1:0]  alu_alu_op,
  input  logic [31:0] alu_result,
  output logic [31:0] rsp_data,
  output logic        c_rsp_valid,
  output logic        f_rsp_valid
);
  typedef enum logic [1:0] {ARB, LOCK, YIELD} state_t;
  state_t state, state_n;
  logic last_f;
  logic [7:0] lock_cnt, lock_cnt_n;
  logic c_xfer, f_xfer;
  // grants: round-robin in ARB, filter-only in LOCK, core-first in YIELD
  always_comb begin
    c_ready = !rst && c_valid && ((state == ARB && (!f_valid || last_f)) || state == YIELD);
    f_ready = !rst && f_valid && ((state == ARB && (!c_valid || !last_f)) || state == LOCK ||
                                  (state == YIELD && !c_valid));
  end
  assign c_xfer      = c_valid & c_ready;
  assign f_xfer      = f_valid & f_ready;
  assign alu_op1     = f_ready ? f_op1 : c_op1;
  assign alu_op2     = f_ready ? f_op2 : c_op2;
  assign alu_func3   = f_ready ? f_func3 : c_func3;
  assign alu_instr30 = f_ready ? f_instr30 : c_instr30;
  assign alu_alu_op  = f_ready ? f_alu_op : c_alu_op;
  // next state and lock counter; hitting the cap wins over a lock release
  always_comb begin
    state_n    = state;
    lock_cnt_n = lock_cnt;
    case (state)
      ARB: if (f_xfer && f_lock) begin
        state_n    = LOCK;
        lock_cnt_n = 8'd1;
      end
      LOCK: if (f_xfer && lock_cnt + 8'd1 == 8'(LOCK_MAX)) begin
        state_n    = YIELD;
        lock_cnt_n = '0;
      end else if (!f_lock) begin
        state_n    = ARB;
        lock_cnt_n = '0;
      end else lock_cnt_n = lock_cnt + 8'(f_xfer);
      default: state_n = ARB;
    endcase
  end
  // state, arbitration history and the registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB;
      last_f      <= 1'b1;
      lock_cnt    <= '0;
      rsp_data    <= '0;
      c_rsp_valid <= 1'b0;
      f_rsp_valid <= 1'b0;
    end else begin
      state       <= state_n;
      lock_cnt    <= lock_cnt_n;
      c_rsp_valid <= c_xfer;
      f_rsp_valid <= f_xfer;
      if (c_xfer || f_xfer) begin
        last_f   <= f_xfer;
        rsp_data <= alu_result;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenario checks of the ALU arbiter
module tb_alu_arbiter;
  logic clk = 0, rst = 1;
  logic c_valid = 0, c_ready, c_instr30 = 0;
  logic [31:0] c_op1 = 0, c_op2 = 0;
  logic [2:0] c_func3 = 0;
  logic [1:0] c_alu_op = 0;
  logic f_valid = 0, f_ready, f_lock = 0, f_instr30 = 0;
  logic [31:0] f_op1 = 0, f_op2 = 0;
  logic [2:0] f_func3 = 0;
  logic [1:0] f_alu_op = 0;
  logic [31:0] alu_op1, alu_op2, alu_result, rsp_data, r;
  logic [2:0] alu_func3;
  logic alu_instr30, c_rsp_valid, f_rsp_valid;
  logic [1:0] alu_alu_op;
  int n_assert = 0, n_fail = 0;

  alu_arbiter #(.LOCK_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .c_valid(c_valid), .c_ready(c_ready), .c_op1(c_op1), .c_op2(c_op2),
    .c_func3(c_func3), .c_instr30(c_instr30), .c_alu_op(c_alu_op),
    .f_valid(f_valid), .f_ready(f_ready), .f_lock(f_lock), .f_op1(f_op1), .f_op2(f_op2),
    .f_func3(f_func3), .f_instr30(f_instr30), .f_alu_op(f_alu_op),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_func3(alu_func3),
    .alu_instr30(alu_instr30), .alu_alu_op(alu_alu_op), .alu_result(alu_result),
    .rsp_data(rsp_data), .c_rsp_valid(c_rsp_valid), .f_rsp_valid(f_rsp_valid)
  );

  always #5 clk = ~clk;

  always_comb begin
    r = '0;
    case (alu_alu_op)
      2'b00: r = alu_op1 + alu_op2;
      2'b10: r = alu_op2;
      default: case (alu_func3)
        3'b000: r = alu_instr30 ? alu_op1 - alu_op2 : alu_op1 + alu_op2;
        3'b010: r = {31'b0, $signed(alu_op1) < $signed(alu_op2)};
        3'b011: r = {31'b0, alu_op1 < alu_op2};
        3'b100: r = alu_op1 ^ alu_op2;
        3'b110: r = alu_op1 | alu_op2;
        3'b111: r = alu_op1 & alu_op2;
        default: r = '0;
      endcase
    endcase
  end
  assign alu_result = r;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1; c_valid = 0; f_valid = 0; f_lock = 0;
    cyc(); cyc();
    rst = 0;
  endtask

  task automatic c_one;
    c_valid = 1; c_alu_op = 2'b00; c_op1 = 1; c_op2 = 2;
    cyc();
    c_valid = 0;
  endtask

  task automatic test_reset;
    rst = 1; c_valid = 1; f_valid = 1;
    cyc();
    @(negedge clk);
    n_assert++;
    if (c_ready !== 1'b0 || f_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_grants c_ready=%b f_ready=%b want 0 0", c_ready, f_ready);
    end
    cyc();
    rst = 0; c_valid = 0; f_valid = 0;
    @(negedge clk);
    n_assert++;
    if (c_rsp_valid !== 1'b0 || f_rsp_valid !== 1'b0 || rsp_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_rsp c=%b f=%b data=%h want 0 0 0", c_rsp_valid, f_rsp_valid, rsp_data);
    end
    cyc();
  endtask

  task automatic test_c_only;
    do_reset();
    c_valid = 1; c_alu_op = 2'b00; c_op1 = 5; c_op2 = 7;
    @(negedge clk);
    n_assert++;
    if (c_ready !== 1'b1 || f_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL c_only_grant c_ready=%b f_ready=%b want 1 0", c_ready, f_ready);
    end
    cyc();
    c_alu_op = 2'b10; c_op2 = 32'h55;
    @(negedge clk);
    n_assert++;
    if (c_rsp_valid !== 1'b1 || f_rsp_valid !== 1'b0 || rsp_data !== 32'd12) begin
      n_fail++;
      $display("FAIL c_only_add c=%b f=%b data=%0d want 1 0 12", c_rsp_valid, f_rsp_valid, rsp_data);
    end
    cyc();
    c_valid = 0;
    @(negedge clk);
    n_assert++;
    if (c_rsp_valid !== 1'b1 || rsp_data !== 32'h55) begin
      n_fail++;
      $display("FAIL c_back_to_back c=%b data=%h want 1 55", c_rsp_valid, rsp_data);
    end
    cyc();
    @(negedge clk);
    n_assert++;
    if (c_rsp_valid !== 1'b0 || f_rsp_valid !== 1'b0 || rsp_data !== 32'h55) begin
      n_fail++;
      $display("FAIL idle_hold c=%b f=%b data=%h want 0 0 55", c_rsp_valid, f_rsp_valid, rsp_data);
    end
  endtask

  task automatic test_round_robin;
    logic exp_c [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    c_valid = 1; c_alu_op = 2'b00; c_op1 = 1; c_op2 = 2;
    f_valid = 1; f_lock = 0; f_alu_op = 2'b01; f_func3 = 3'b010; f_instr30 = 0;
    f_op1 = 32'hFFFF_FFFF; f_op2 = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_assert++;
        if (c_rsp_valid !== exp_c[i-1] || f_rsp_valid !== !exp_c[i-1] ||
            rsp_data !== (exp_c[i-1] ? 32'd3 : 32'd1)) begin
          n_fail++;
          $display("FAIL rr_rsp%0d c=%b f=%b data=%0d want c=%b data=%0d", i - 1, c_rsp_valid,
                   f_rsp_valid, rsp_data, exp_c[i-1], exp_c[i-1] ? 3 : 1);
        end
      end
      if (i < 4) begin
        n_assert++;
        if (c_ready !== exp_c[i] || f_ready !== !exp_c[i]) begin
          n_fail++;
          $display("FAIL rr_grant%0d c_ready=%b f_ready=%b want c_ready=%b", i, c_ready, f_ready, exp_c[i]);
        end
        cyc();
        if (i == 3) begin
          c_valid = 0; f_valid = 0;
        end
      end
    end
  endtask

  task automatic test_lock_burst;
    logic exp_f;
    do_reset();
    c_one();
    c_valid = 1; c_alu_op = 2'b00;
    f_valid = 1; f_lock = 1; f_alu_op = 2'b01; f_func3 = 3'b011; f_op1 = 1; f_op2 = 2;
    for (int i = 0; i < 11; i++) begin
      exp_f = (i != 8);
      @(negedge clk);
      n_assert++;
      if (f_ready !== exp_f || c_ready !== !exp_f) begin
        n_fail++;
        $display("FAIL lock_burst%0d f_ready=%b c_ready=%b want f_ready=%b", i, f_ready, c_ready, exp_f);
      end
      if (i > 0 && f_rsp_valid !== (i != 9)) begin
        n_fail++;
        $display("FAIL lock_rsp%0d f_rsp_valid=%b want %b", i, f_rsp_valid, i != 9);
      end
      if (i > 0) n_assert++;
      cyc();
    end
    c_valid = 0; f_valid = 0; f_lock = 0;
  endtask

  task automatic test_lock_release;
    logic exp_f;
    do_reset();
    c_one();
    c_valid = 1; f_valid = 1; f_lock = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) f_lock = 0;
      exp_f = (i < 4);
      @(negedge clk);
      n_assert++;
      if (f_ready !== exp_f || c_ready !== !exp_f) begin
        n_fail++;
        $display("FAIL lock_release%0d f_ready=%b c_ready=%b want f_ready=%b", i, f_ready, c_ready, exp_f);
      end
      cyc();
    end
    c_valid = 0; f_valid = 0;
  endtask

  task automatic test_yield_c_idle;
    logic exp_f;
    do_reset();
    c_one();
    f_valid = 1; f_lock = 1; f_alu_op = 2'b01; f_func3 = 3'b010; f_op1 = 32'hFFFF_FFFF; f_op2 = 1;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) c_valid = 1;
      exp_f = (i < 9);
      @(negedge clk);
      n_assert++;
      if (f_ready !== exp_f || c_ready !== !exp_f) begin
        n_fail++;
        $display("FAIL yield_idle%0d f_ready=%b c_ready=%b want f_ready=%b", i, f_ready, c_ready, exp_f);
      end
      cyc();
    end
    c_valid = 0; f_valid = 0; f_lock = 0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    c_valid = 1; c_alu_op = 2'b01; c_func3 = 3'b000; c_instr30 = 1; c_op1 = 10; c_op2 = 3;
    cyc();
    rst = 1; f_valid = 1;
    @(negedge clk);
    n_assert++;
    if (c_ready !== 1'b0 || f_ready !== 1'b0 || c_rsp_valid !== 1'b1 || rsp_data !== 32'd7) begin
      n_fail++;
      $display("FAIL reset_mid_pre c_ready=%b f_ready=%b c_rsp=%b data=%0d want 0 0 1 7",
               c_ready, f_ready, c_rsp_valid, rsp_data);
    end
    cyc();
    @(negedge clk);
    n_assert++;
    if (c_rsp_valid !== 1'b0 || f_rsp_valid !== 1'b0 || rsp_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_post c=%b f=%b data=%0d want 0 0 0", c_rsp_valid, f_rsp_valid, rsp_data);
    end
    rst = 0; c_valid = 0; f_valid = 0; c_instr30 = 0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_c_only();
    test_round_robin();
    test_lock_burst();
    test_lock_release();
    test_yield_c_idle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
